// File: rtl/audio_pkg.sv
// Shared constants and helpers for the PWM audio output stage.
//   SAMPLE_W  : width of the signed generator amplitude
//   DUTY_W    : width of the PWM duty / counter
//   MIDSCALE  : duty value for silence (50 % density)
//   to_offset : signed two's-complement sample -> unsigned offset-binary duty
package audio_pkg;

    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned DUTY_W   = 8;
    localparam logic [DUTY_W-1:0] MIDSCALE = 8'd128;

    // Flipping the sign bit maps -128..127 onto 0..255 without an adder.
    function automatic logic [DUTY_W-1:0] to_offset(input logic signed [SAMPLE_W-1:0] s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/audio_modulator.sv
// 1-bit output modulator driven by the frame-synchronous duty value.
// Build option: define PWM_AUDIO_DELTA_SIGMA_EN to replace the PWM compare
// with a first-order delta-sigma modulator (same average density).
// Ports:
//   clk_in, rst_in : clock, asynchronous active-high reset
//   enable_in      : low forces the pin to 0 and clears modulator state
//   pwm_cnt        : free-running frame counter from the top
//   duty_act       : active duty, stable for a whole frame
//   audio_out      : registered 1-bit audio pin
module audio_modulator
    import audio_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              enable_in,
    input  logic [DUTY_W-1:0] pwm_cnt,
    input  logic [DUTY_W-1:0] duty_act,
    output logic              audio_out
);

`ifdef PWM_AUDIO_DELTA_SIGMA_EN

    // Frame counter is not needed by the delta-sigma variant.
    logic unused_pwm_cnt;
    assign unused_pwm_cnt = ^pwm_cnt;

    logic [DUTY_W:0] acc;

    // Carry out of the 8-bit accumulator is the output bit; density = duty/256.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc       <= '0;
            audio_out <= 1'b0;
        end else if (!enable_in) begin
            acc       <= '0;
            audio_out <= 1'b0;
        end else begin
            acc       <= {1'b0, acc[DUTY_W-1:0]} + {1'b0, duty_act};
            audio_out <= acc[DUTY_W];
        end
    end

`else

    // Unsigned 8-bit compare: duty 0 -> never high, duty 255 -> 255 of 256.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            audio_out <= 1'b0;
        end else begin
            audio_out <= enable_in && (pwm_cnt < duty_act);
        end
    end

`endif

endmodule

// File: rtl/pwm_audio_out.sv
// Sample-rate master and 1-bit audio output stage.
// Issues the periodic step strobe to the tone generators, captures their
// amplitude a fixed delay later, and reloads the modulator duty only at
// frame boundaries so the output never glitches mid-frame.
// Build option: PWM_AUDIO_DELTA_SIGMA_EN (see audio_modulator).
// Ports:
//   clk_in, rst_in : clock, asynchronous active-high reset
//   enable_in      : run/stop; low stops strobes and forces midscale/idle
//   sample_in      : signed 8-bit amplitude from the generator
//   step_out       : one-cycle sample strobe to the generators
//   audio_out      : registered PWM/PDM bit to the pin
//   frame_out      : one-cycle pulse in the cycle the new duty goes live
module pwm_audio_out
    import audio_pkg::*;
#(
    parameter int unsigned STEP_PERIOD   = 2272,
    parameter int unsigned CAPTURE_DELAY = 3
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                enable_in,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic                step_out,
    output logic                audio_out,
    output logic                frame_out
);

    localparam int unsigned DIV_W = 16;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(STEP_PERIOD - 1);
    localparam logic [DUTY_W-1:0] PWM_LAST = '1;

    logic [DIV_W-1:0]         div_cnt;
    logic [CAPTURE_DELAY-1:0] cap_pipe;
    logic [DUTY_W-1:0]        hold;
    logic [DUTY_W-1:0]        duty_act;
    logic [DUTY_W-1:0]        pwm_cnt;

    logic div_last_c;
    logic capture_c;
    logic frame_end_c;

    assign div_last_c  = (div_cnt == DIV_LAST);
    assign capture_c   = cap_pipe[CAPTURE_DELAY-1];
    assign frame_end_c = (pwm_cnt == PWM_LAST);

    // Sample-rate divider and step strobe.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div_cnt  <= '0;
            step_out <= 1'b0;
        end else if (!enable_in) begin
            div_cnt  <= '0;
            step_out <= 1'b0;
        end else begin
            div_cnt  <= div_last_c ? '0 : div_cnt + DIV_W'(1);
            step_out <= div_last_c;
        end
    end

    // Delay line giving the generators time to produce the new amplitude.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cap_pipe <= '0;
        end else if (!enable_in) begin
            cap_pipe <= '0;
        end else begin
            cap_pipe <= (cap_pipe << 1) | CAPTURE_DELAY'(step_out);
        end
    end

    // Captured sample in offset binary, waiting for the next frame boundary.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hold <= MIDSCALE;
        end else if (!enable_in) begin
            hold <= MIDSCALE;
        end else if (capture_c) begin
            hold <= to_offset(sample_in);
        end
    end

    // Frame counter and frame-synchronous duty reload; a capture landing on
    // the reload edge is picked up one frame later (reload sees old hold).
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pwm_cnt   <= '0;
            duty_act  <= MIDSCALE;
            frame_out <= 1'b0;
        end else if (!enable_in) begin
            pwm_cnt   <= '0;
            duty_act  <= MIDSCALE;
            frame_out <= 1'b0;
        end else begin
            pwm_cnt   <= pwm_cnt + DUTY_W'(1);
            frame_out <= frame_end_c;
            if (frame_end_c) begin
                duty_act <= hold;
            end
        end
    end

    audio_modulator u_mod (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .enable_in (enable_in),
        .pwm_cnt   (pwm_cnt),
        .duty_act  (duty_act),
        .audio_out (audio_out)
    );

endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out (PWM build) with STEP_PERIOD=300.
// Inputs change on the falling edge; a monitor samples #1 after the rising
// edge and checks step strobes and per-frame high counts against queues of
// expected values pushed by the stimulus.
module tb_pwm_audio_out;

    localparam int unsigned STEP_PERIOD   = 300;
    localparam int unsigned CAPTURE_DELAY = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] sample;
    logic       step;
    logic       audio;
    logic       frame;

    int unsigned cyc;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned frame_hi = 0;
    int unsigned step_q[$];
    int unsigned frame_q[$];

    pwm_audio_out #(
        .STEP_PERIOD   (STEP_PERIOD),
        .CAPTURE_DELAY (CAPTURE_DELAY)
    ) dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .enable_in (enable),
        .sample_in (sample),
        .step_out  (step),
        .audio_out (audio),
        .frame_out (frame)
    );

    always #5 clk = ~clk;

    // Cycle index: edge k after reset release gives cyc == k.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Wait until the falling edge inside cycle t; inputs set here hit edge t+1.
    task automatic go_to(input int unsigned t);
        do @(negedge clk); while (cyc < t);
    endtask

    // Monitor: step times and high count of each completed frame.
    always @(posedge clk) begin
        #1;
        if (rst || !enable) begin
            frame_hi = 0;
        end else begin
            if (step) begin
                check("step_expected", 32'(step_q.size() != 0), 32'd1);
                if (step_q.size() != 0) check("step_cycle", cyc, step_q.pop_front());
            end
            frame_hi += 32'(audio);
            if (frame) begin
                if (frame_q.size() != 0) check("frame_high_count", frame_hi, frame_q.pop_front());
                frame_hi = 0;
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        sample = 8'h7F;
        repeat (3) @(negedge clk);

        check("rst_step",     32'(step),         32'd0);
        check("rst_audio",    32'(audio),        32'd0);
        check("rst_frame",    32'(frame),        32'd0);
        check("rst_div_cnt",  32'(dut.div_cnt),  32'd0);
        check("rst_pwm_cnt",  32'(dut.pwm_cnt),  32'd0);
        check("rst_hold",     32'(dut.hold),     32'd128);
        check("rst_duty_act", 32'(dut.duty_act), 32'd128);

        // Epoch 1: 7F captured at 303 -> live from 512; 80 captured at 903;
        // 00 captured at 1203; +64 captured at 1503 mid-frame -> live at 1536.
        for (int m = 1; m <= 6; m++) step_q.push_back(STEP_PERIOD * m);
        frame_q.push_back(128);
        frame_q.push_back(128);
        frame_q.push_back(255);
        frame_q.push_back(255);
        frame_q.push_back(0);
        frame_q.push_back(128);
        frame_q.push_back(192);
        rst = 1'b0;

        go_to(303);
        check("hold_before_capture", 32'(dut.hold), 32'd128);
        go_to(304);
        check("hold_after_capture", 32'(dut.hold), 32'd255);

        go_to(700);
        sample = 8'h80;
        go_to(1000);
        sample = 8'h00;
        go_to(1502);
        sample = 8'h40;

        go_to(1535);
        check("frame_1535", 32'(frame), 32'd0);
        go_to(1536);
        check("frame_1536", 32'(frame), 32'd1);
        go_to(1537);
        check("frame_1537", 32'(frame), 32'd0);

        // Disable for 10 edges (1901..1910) mid-frame.
        go_to(1900);
        enable = 1'b0;
        step_q.push_back(2210);
        step_q.push_back(2510);
        frame_q.push_back(128);
        frame_q.push_back(128);
        for (int c = 1901; c <= 1910; c++) begin
            go_to(c);
            check("dis_step",  32'(step),  32'd0);
            check("dis_audio", 32'(audio), 32'd0);
            check("dis_frame", 32'(frame), 32'd0);
            if (c == 1905) begin
                check("dis_hold",     32'(dut.hold),     32'd128);
                check("dis_duty_act", 32'(dut.duty_act), 32'd128);
            end
        end
        enable = 1'b1;

        go_to(2166);
        check("frame_after_enable", 32'(frame), 32'd1);

        go_to(2500);
        sample = 8'h7F;
        go_to(2510);
        check("step_2510", 32'(step), 32'd1);

        // Async reset in the middle of a pending capture.
        go_to(2511);
        check("audio_before_reset", 32'(audio), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_step",     32'(step),         32'd0);
        check("arst_audio",    32'(audio),        32'd0);
        check("arst_frame",    32'(frame),        32'd0);
        check("arst_pipe",     32'(dut.cap_pipe), 32'd0);
        check("arst_duty_act", 32'(dut.duty_act), 32'd128);

        step_q.push_back(STEP_PERIOD);
        step_q.push_back(STEP_PERIOD * 2);
        frame_q.push_back(128);
        frame_q.push_back(128);
        frame_q.push_back(255);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        go_to(5);
        check("discarded_capture_hold", 32'(dut.hold), 32'd128);
        go_to(303);
        check("epoch2_hold_before", 32'(dut.hold), 32'd128);
        go_to(304);
        check("epoch2_hold_after", 32'(dut.hold), 32'd255);

        go_to(800);
        check("steps_outstanding",  32'(step_q.size()),  32'd0);
        check("frames_outstanding", 32'(frame_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
